// File: rtl/pb_repeat_pulser_if.sv
// rtl/pb_repeat_pulser_if.sv - push-button pulser signal bundle
interface pb_repeat_pulser_if;
    logic pb_in;
    logic repeat_en;
    logic pulse_out;
    logic pb_state;
    logic repeating;

    modport master (
        output pb_in,
        output repeat_en,
        input  pulse_out,
        input  pb_state,
        input  repeating
    );

    modport slave (
        input  pb_in,
        input  repeat_en,
        output pulse_out,
        output pb_state,
        output repeating
    );
endinterface

// File: rtl/pb_repeat_pulser.sv
// rtl/pb_repeat_pulser.sv - debounced push-button to press/auto-repeat enable pulses
module pb_repeat_pulser #(
    parameter int DB_COUNT      = 16,
    parameter int DB_W          = 16,
    parameter int HOLD_DELAY    = 25000000,
    parameter int REPEAT_PERIOD = 5000000,
    parameter int TMR_W         = 25
) (
    input  logic                clock,
    input  logic                reset,
    pb_repeat_pulser_if.slave   bus
);
    localparam logic [DB_W-1:0]  DB_LAST   = DB_W'(DB_COUNT - 1);
    localparam logic [TMR_W-1:0] HOLD_LAST = TMR_W'(HOLD_DELAY - 1);
    localparam logic [TMR_W-1:0] REP_LAST  = TMR_W'(REPEAT_PERIOD - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HOLD   = 2'd1,
        REPEAT = 2'd2
    } state_t;

    logic             s1;
    logic             s2;
    logic [DB_W-1:0]  dbc;
    logic             level;
    logic             settle;
    logic             rise;
    logic             fall;
    state_t           state;
    logic [TMR_W-1:0] timer;
    logic             pulse;
    logic             rep;

    // The debounced level flips on this cycle; the FSM reacts on the same
    // edge so the press pulse lines up with the pb_state rise.
    assign settle = (s2 != level) && (dbc == DB_LAST);
    assign rise   = settle && s2;
    assign fall   = settle && !s2;

    // Two-flop synchroniser for the asynchronous button input.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= bus.pb_in;
            s2 <= s1;
        end
    end

    // Debounce: the level follows s2 only after DB_COUNT consecutive mismatches.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            dbc   <= '0;
            level <= 1'b0;
        end else if (s2 == level) begin
            dbc <= '0;
        end else if (dbc == DB_LAST) begin
            level <= s2;
            dbc   <= '0;
        end else begin
            dbc <= dbc + DB_W'(1);
        end
    end

    // Press/hold/repeat FSM with registered pulse and repeating flags.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            timer <= '0;
            pulse <= 1'b0;
            rep   <= 1'b0;
        end else begin
            pulse <= 1'b0;
            if (fall) begin
                // Release beats any timer expiry landing on the same cycle.
                state <= IDLE;
                timer <= '0;
                rep   <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (rise) begin
                            pulse <= 1'b1;
                            timer <= '0;
                            state <= HOLD;
                        end
                    end
                    HOLD: begin
                        // Timer parks at the last count while repeat is disabled,
                        // so re-enabling fires on the very next cycle.
                        if (timer == HOLD_LAST) begin
                            if (bus.repeat_en) begin
                                pulse <= 1'b1;
                                timer <= '0;
                                rep   <= 1'b1;
                                state <= REPEAT;
                            end
                        end else begin
                            timer <= timer + TMR_W'(1);
                        end
                    end
                    REPEAT: begin
                        if (!bus.repeat_en) begin
                            timer <= HOLD_LAST;
                            rep   <= 1'b0;
                            state <= HOLD;
                        end else if (timer == REP_LAST) begin
                            pulse <= 1'b1;
                            timer <= '0;
                        end else begin
                            timer <= timer + TMR_W'(1);
                        end
                    end
                    default: begin
                        state <= IDLE;
                        timer <= '0;
                        rep   <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.pulse_out = pulse;
    assign bus.pb_state  = level;
    assign bus.repeating = rep;
endmodule

// File: tb/tb_pb_repeat_pulser.sv
// tb/tb_pb_repeat_pulser.sv - self-checking bench for pb_repeat_pulser
module tb_pb_repeat_pulser;
    localparam int DB  = 4;
    localparam int HD  = 10;
    localparam int RP  = 3;

    logic clock = 1'b0;
    logic reset = 1'b0;

    pb_repeat_pulser_if bus ();

    pb_repeat_pulser #(
        .DB_COUNT      (DB),
        .DB_W          (4),
        .HOLD_DELAY    (HD),
        .REPEAT_PERIOD (RP),
        .TMR_W         (5)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: debounced level from a window over the synced sample
    // history; pulses scheduled by absolute due-cycle arithmetic.
    bit hist[$];
    int k;
    bit lvl;
    bit m_pulse;
    bit m_held;
    bit m_rep;
    int due;
    bit prev_pulse;

    function automatic bit s2_at(int e);
        if (e < 2) return 1'b0;
        return hist[e-2];
    endfunction

    task automatic model_reset();
        hist.delete();
        k       = 0;
        lvl     = 1'b0;
        m_pulse = 1'b0;
        m_held  = 1'b0;
        m_rep   = 1'b0;
        due     = 0;
        prev_pulse = 1'b0;
    endtask

    task automatic model_edge(bit pb, bit ren);
        bit flip;
        hist.push_back(pb);
        flip = 1'b1;
        for (int j = 0; j < DB; j++)
            if (s2_at(k - j) == lvl) flip = 1'b0;
        m_pulse = 1'b0;
        if (flip) begin
            lvl = !lvl;
            if (lvl) begin
                m_pulse = 1'b1;
                m_held  = 1'b1;
                m_rep   = 1'b0;
                due     = k + HD;
            end else begin
                m_held = 1'b0;
                m_rep  = 1'b0;
            end
        end else if (m_held) begin
            if (m_rep && !ren) begin
                m_rep = 1'b0;
                due   = k + 1;
            end else if (k >= due && ren) begin
                m_pulse = 1'b1;
                m_rep   = 1'b1;
                due     = k + RP;
            end
        end
        k++;
    endtask

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    // One clock: drive at negedge, model at posedge, compare at next negedge.
    task automatic step(bit pb, bit ren);
        bus.pb_in     = pb;
        bus.repeat_en = ren;
        @(posedge clock);
        model_edge(pb, ren);
        @(negedge clock);
        check("pulse_out", bus.pulse_out, m_pulse);
        check("pb_state", bus.pb_state, lvl);
        check("repeating", bus.repeating, m_rep);
        check("no_back_to_back", bus.pulse_out & prev_pulse, 0);
        prev_pulse = bus.pulse_out;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        check("rst_pulse_out", bus.pulse_out, 0);
        check("rst_pb_state", bus.pb_state, 0);
        check("rst_repeating", bus.repeating, 0);
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        model_reset();
    endtask

    initial begin
        int npulse;
        int plist[$];
        int exp_p[8];
        bit seen_hi;
        bit ren;

        bus.pb_in     = 1'b0;
        bus.repeat_en = 1'b0;
        model_reset();
        @(negedge clock);

        // Reset state, then idle with the button up.
        do_reset();
        npulse = 0;
        for (int i = 1; i <= 50; i++) begin
            step(1'b0, 1'b0);
            npulse += int'(bus.pulse_out);
        end
        check("idle_pulses", npulse, 0);

        // Single 8-cycle press with repeat disabled.
        npulse = 0;
        for (int i = 1; i <= 20; i++) begin
            step(i <= 8, 1'b0);
            npulse += int'(bus.pulse_out);
            if (i == 5)  check("s2_state_c5", bus.pb_state, 0);
            if (i == 6)  check("s2_pulse_c6", bus.pulse_out, 1);
            if (i == 6)  check("s2_state_c6", bus.pb_state, 1);
            if (i == 13) check("s2_state_c13", bus.pb_state, 1);
            if (i == 14) check("s2_state_c14", bus.pb_state, 0);
        end
        check("s2_pulse_count", npulse, 1);

        // Three-cycle glitch is filtered.
        npulse  = 0;
        seen_hi = 1'b0;
        for (int i = 1; i <= 15; i++) begin
            step(i <= 3, 1'b0);
            npulse += int'(bus.pulse_out);
            if (bus.pb_state) seen_hi = 1'b1;
        end
        check("glitch_pulses", npulse, 0);
        check("glitch_state", seen_hi, 0);

        // 30-cycle hold with auto-repeat.
        exp_p = '{6, 16, 19, 22, 25, 28, 31, 34};
        plist.delete();
        for (int i = 1; i <= 45; i++) begin
            step(i <= 30, 1'b1);
            if (bus.pulse_out) plist.push_back(i);
            if (i == 15) check("s4_rep_c15", bus.repeating, 0);
            if (i == 16) check("s4_rep_c16", bus.repeating, 1);
            if (i == 35) check("s4_rep_c35", bus.repeating, 1);
            if (i == 36) check("s4_rep_c36", bus.repeating, 0);
        end
        check("s4_pulse_count", plist.size(), 8);
        for (int j = 0; j < 8; j++)
            check("s4_pulse_cycle", (j < plist.size()) ? plist[j] : -1, exp_p[j]);

        // Release lands on a repeat cycle: no pulse.
        for (int i = 1; i <= 45; i++) begin
            step(i <= 31, 1'b1);
            if (i == 34) check("s5_pulse_c34", bus.pulse_out, 1);
            if (i == 37) check("s5_pulse_c37", bus.pulse_out, 0);
            if (i == 37) check("s5_state_c37", bus.pb_state, 0);
            if (i == 37) check("s5_rep_c37", bus.repeating, 0);
        end

        // Reset mid-HOLD with the button still held.
        for (int i = 1; i <= 12; i++) step(1'b1, 1'b0);
        check("s6_held", bus.pb_state, 1);
        do_reset();
        npulse = 0;
        for (int i = 1; i <= 12; i++) begin
            step(1'b1, 1'b0);
            npulse += int'(bus.pulse_out);
            if (i == 6) check("s6_pulse_c6", bus.pulse_out, 1);
        end
        check("s6_pulse_count", npulse, 1);
        for (int i = 1; i <= 10; i++) step(1'b0, 1'b0);

        // Randomised segments against the model.
        ren = 1'b1;
        for (int seg = 0; seg < 120; seg++) begin
            bit lv;
            int len;
            lv = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 2))
                0:       len = $urandom_range(1, DB);
                1:       len = $urandom_range(4, 12);
                default: len = $urandom_range(15, 50);
            endcase
            if ($urandom_range(0, 24) == 0) do_reset();
            for (int c = 0; c < len; c++) begin
                if ($urandom_range(0, 9) == 0) ren = !ren;
                step(lv, ren);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
